read_burst_splitter: RTL and testbench
======================================

Name: read_burst_splitter

Overview:
- Device-side command front end, clocked on devclock_in, directly upstream of the AXI read master.
- Accepts one large read command (start address, total beat count, size, burst type, protection bits) from the device.
- Splits it into legal AXI3 bursts of at most 16 beats that never cross a 4 KB boundary.
- Presents each burst to the read master's device-input pins and holds it until the master acknowledges.

Parameters:
BusWidth, 32, address width in bits
MaxBeats, 16, maximum beats per issued burst (ARLEN is 4 bits)
BoundaryBytes, 4096, address boundary no INCR burst may cross (power of two)

Ports:
devclock_in  input  1  device clock; all logic on rising edge
ARESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  device command valid
cmd_ready  output  1  block can accept a command
cmd_addr  input  BusWidth  start byte address
cmd_beats  input  16  total beats requested; 0 = no-op
cmd_size  input  2  bytes per beat = 1<<cmd_size
cmd_burst  input  2  00 FIXED, 01 INCR; 10/11 treated as INCR
cmd_prot  input  3  protection bits, passed through per burst
cmd_done  output  1  one-cycle pulse when the whole command is issued
address_out  output  BusWidth  burst start address (to master address_in)
memoryRead_out  output  1  burst request (to master memoryRead_in)
len_out  output  4  beats-1 (to master len_in)
size_out  output  2  to master size_in
burst_out  output  2  to master burst_in
prot_out  output  3  to master prot_in
burst_ack  input  1  single-cycle pulse, devclock domain: master accepted current burst
busy  output  1  high whenever state != IDLE
bursts_issued  output  8  wrapping count of acknowledged bursts since reset

Behaviour:
- Reset (async, ARESETn low): state IDLE. All outputs 0 except cmd_ready=1. Internal address, remaining and chunk registers cleared. A reset mid-command abandons the command; no cmd_done is generated.
- All outputs are registered. No combinational path from inputs to outputs.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch addr with the low cmd_size bits forced to 0, plus beats, size, burst and prot.
  - If cmd_beats==0: pulse cmd_done next cycle and stay IDLE.
  - Otherwise go to CALC.
- State CALC (1 cycle):
  - to_bound = (BoundaryBytes - (addr mod BoundaryBytes)) >> size.
  - INCR: chunk = min(remaining, MaxBeats, to_bound).
  - FIXED: chunk = min(remaining, MaxBeats); no boundary check.
  - chunk is always >=1. Go to ISSUE.
- State ISSUE (1 cycle):
  - Drive address_out=addr, len_out=chunk-1, size_out, burst_out, prot_out.
  - Set memoryRead_out=1. Go to WAIT_ACK.
- State WAIT_ACK:
  - memoryRead_out and all burst fields held stable until burst_ack.
  - On burst_ack: memoryRead_out=0 next cycle; remaining -= chunk; bursts_issued += 1.
  - INCR: addr += chunk<<size. FIXED: addr unchanged.
  - If remaining becomes 0: pulse cmd_done for 1 cycle and go to IDLE. Otherwise go to CALC.
- memoryRead_out is low for at least one cycle between consecutive bursts, because CALC intervenes. This gives the master a clean re-arm.
- burst_ack outside WAIT_ACK is ignored and does not change the counter.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Address arithmetic is modulo 2^BusWidth; the 4 KB split prevents wrap within a burst.
- Minimum per-burst latency: command accept -> memoryRead_out high is 2 cycles (CALC, ISSUE).

Decomposition:
- Shared package (axi_read_pkg):
  - Burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - State encoding IDLE/CALC/ISSUE/WAIT_ACK as 2-bit localparams.
  - AXI3 max-length constant 16 and the 4 KB boundary constant.
- Sub-module: burst_chunk_calc, a combinational min(remaining, MaxBeats, to_bound) given addr, size, burst and remaining. It is registered into chunk in CALC and is unit-testable alone.

Test Plan:
- Reset high-to-low during WAIT_ACK -> all outputs 0, cmd_ready=1, no cmd_done, bursts_issued=0.
- INCR addr=0x1000, beats=40, size=2 (4B), ack each burst -> bursts (0x1000,len 15), (0x1040,len 15), (0x1080,len 7); cmd_done after third ack; bursts_issued=3.
- INCR addr=0x0FF0, beats=10, size=2 -> 4 KB split: (0x0FF0,len 3) then (0x1000,len 5); cmd_done after second ack.
- FIXED addr=0x2004, beats=20, size=2 -> (0x2004,len 15) then (0x2004,len 3); address unchanged.
- cmd_beats=0 -> cmd_done one cycle after accept, memoryRead_out never asserted; also inject a stray burst_ack in IDLE -> counter unchanged.
- Unaligned addr=0x1003, size=2, beats=1 -> address_out=0x1000, len_out=0. burst_ack delayed 5 cycles -> memoryRead_out and fields stable throughout the wait, and low for >=1 cycle before the next burst.

Source files
------------

// File: rtl/axi_read_pkg.sv
// rtl/axi_read_pkg.sv - shared burst/state encodings and AXI3 limits for the read front end
package axi_read_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CALC     = 2'd1;
    localparam logic [1:0] ST_ISSUE    = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        CALC     = ST_CALC,
        ISSUE    = ST_ISSUE,
        WAIT_ACK = ST_WAIT_ACK
    } split_state_t;

    localparam int AXI3_MAX_BEATS = 16;
    localparam int BOUNDARY_4K    = 4096;

endpackage

// File: rtl/burst_chunk_calc.sv
// rtl/burst_chunk_calc.sv - combinational beat count of the next burst: min(remaining, MaxBeats, beats to boundary)
module burst_chunk_calc
    import axi_read_pkg::*;
#(
    parameter int BusWidth      = 32,
    parameter int MaxBeats      = AXI3_MAX_BEATS,
    parameter int BoundaryBytes = BOUNDARY_4K,
    parameter int ChunkW        = $clog2(MaxBeats) + 1
) (
    input  logic [BusWidth-1:0] i_addr,
    input  logic [1:0]          i_size,
    input  logic [1:0]          i_burst,
    input  logic [15:0]         i_remaining,
    output logic [ChunkW-1:0]   o_chunk
);

    localparam int OffW = $clog2(BoundaryBytes);

    logic [OffW:0] w_offset;
    logic [OffW:0] w_room;
    logic [OffW:0] w_to_bound;
    logic [16:0]   w_min;
    logic          w_incr;

    // Anything that is not FIXED (including the WRAP/reserved codes) is split as INCR.
    assign w_incr     = (i_burst != BURST_FIXED);
    assign w_offset   = {1'b0, i_addr[OffW-1:0]};
    assign w_room     = (OffW+1)'(BoundaryBytes) - w_offset;
    assign w_to_bound = w_room >> i_size;

    always_comb begin
        w_min = 17'(MaxBeats);
        if ({1'b0, i_remaining} < w_min) begin
            w_min = {1'b0, i_remaining};
        end
        if (w_incr && (17'(w_to_bound) < w_min)) begin
            w_min = 17'(w_to_bound);
        end
    end

    assign o_chunk = w_min[ChunkW-1:0];

endmodule

// File: rtl/read_burst_splitter.sv
// rtl/read_burst_splitter.sv - splits one device read command into AXI3 bursts and hands them to the read master
module read_burst_splitter
    import axi_read_pkg::*;
#(
    parameter int BusWidth      = 32,
    parameter int MaxBeats      = AXI3_MAX_BEATS,
    parameter int BoundaryBytes = BOUNDARY_4K
) (
    input  logic                devclock_in,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BusWidth-1:0] cmd_addr,
    input  logic [15:0]         cmd_beats,
    input  logic [1:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [2:0]          cmd_prot,
    output logic                cmd_done,
    output logic [BusWidth-1:0] address_out,
    output logic                memoryRead_out,
    output logic [3:0]          len_out,
    output logic [1:0]          size_out,
    output logic [1:0]          burst_out,
    output logic [2:0]          prot_out,
    input  logic                burst_ack,
    output logic                busy,
    output logic [7:0]          bursts_issued
);

    localparam int ChunkW = $clog2(MaxBeats) + 1;

    split_state_t        r_state;
    logic [BusWidth-1:0] r_addr;
    logic [15:0]         r_remaining;
    logic [ChunkW-1:0]   r_chunk;
    logic [1:0]          r_size;
    logic [1:0]          r_burst;
    logic [2:0]          r_prot;
    logic [ChunkW-1:0]   w_chunk;
    logic [BusWidth-1:0] w_aligned;
    logic [BusWidth-1:0] w_step;

    burst_chunk_calc #(
        .BusWidth      (BusWidth),
        .MaxBeats      (MaxBeats),
        .BoundaryBytes (BoundaryBytes),
        .ChunkW        (ChunkW)
    ) u_chunk (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .i_remaining (r_remaining),
        .o_chunk     (w_chunk)
    );

    assign w_aligned = cmd_addr & ~((BusWidth'(1) << cmd_size) - BusWidth'(1));
    assign w_step    = BusWidth'(r_chunk) << r_size;

    always_ff @(posedge devclock_in or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_chunk        <= '0;
            r_size         <= '0;
            r_burst        <= '0;
            r_prot         <= '0;
            cmd_ready      <= 1'b1;
            cmd_done       <= 1'b0;
            address_out    <= '0;
            memoryRead_out <= 1'b0;
            len_out        <= '0;
            size_out       <= '0;
            burst_out      <= '0;
            prot_out       <= '0;
            busy           <= 1'b0;
            bursts_issued  <= '0;
        end else begin
            cmd_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_addr      <= w_aligned;
                        r_remaining <= cmd_beats;
                        r_size      <= cmd_size;
                        r_burst     <= cmd_burst;
                        r_prot      <= cmd_prot;
                        if (cmd_beats == 16'd0) begin
                            cmd_done <= 1'b1;
                        end else begin
                            r_state   <= CALC;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_chunk <= w_chunk;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    address_out    <= r_addr;
                    len_out        <= 4'(r_chunk - ChunkW'(1));
                    size_out       <= r_size;
                    burst_out      <= r_burst;
                    prot_out       <= r_prot;
                    memoryRead_out <= 1'b1;
                    r_state        <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (burst_ack) begin
                        memoryRead_out <= 1'b0;
                        r_remaining    <= r_remaining - 16'(r_chunk);
                        bursts_issued  <= bursts_issued + 8'd1;
                        if (r_burst != BURST_FIXED) begin
                            r_addr <= r_addr + w_step;
                        end
                        // Going back through CALC keeps memoryRead_out low for a cycle between bursts.
                        if (r_remaining == 16'(r_chunk)) begin
                            cmd_done  <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_burst_splitter.sv
// tb/tb_read_burst_splitter.sv - table-driven self-checking bench for read_burst_splitter
module tb_read_burst_splitter;

    logic        devclock_in = 1'b0;
    logic        ARESETn     = 1'b0;
    logic        cmd_valid   = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr    = '0;
    logic [15:0] cmd_beats   = '0;
    logic [1:0]  cmd_size    = '0;
    logic [1:0]  cmd_burst   = '0;
    logic [2:0]  cmd_prot    = '0;
    logic        cmd_done;
    logic [31:0] address_out;
    logic        memoryRead_out;
    logic [3:0]  len_out;
    logic [1:0]  size_out;
    logic [1:0]  burst_out;
    logic [2:0]  prot_out;
    logic        burst_ack   = 1'b0;
    logic        busy;
    logic [7:0]  bursts_issued;

    read_burst_splitter dut (
        .devclock_in    (devclock_in),
        .ARESETn        (ARESETn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_beats      (cmd_beats),
        .cmd_size       (cmd_size),
        .cmd_burst      (cmd_burst),
        .cmd_prot       (cmd_prot),
        .cmd_done       (cmd_done),
        .address_out    (address_out),
        .memoryRead_out (memoryRead_out),
        .len_out        (len_out),
        .size_out       (size_out),
        .burst_out      (burst_out),
        .prot_out       (prot_out),
        .burst_ack      (burst_ack),
        .busy           (busy),
        .bursts_issued  (bursts_issued)
    );

    always #5 devclock_in = ~devclock_in;

    typedef struct {
        logic [31:0]      addr;
        logic [15:0]      beats;
        logic [1:0]       size;
        logic [1:0]       burst;
        logic [2:0]       prot;
        int               n;
        int               dly;
        logic [3:0][31:0] ea;
        logic [3:0][3:0]  el;
    } vec_t;

    int total   = 0;
    int bad     = 0;
    int exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge devclock_in);
        #1;
    endtask

    task automatic wait_mr(output int w);
        w = 0;
        while (!memoryRead_out && w < 20) begin
            tick();
            w++;
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int          w;
        logic [31:0] a0;
        logic        stable;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_beats = v.beats;
        cmd_size  = v.size;
        cmd_burst = v.burst;
        cmd_prot  = v.prot;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_BEEF;
        if (v.n == 0) begin
            chk("zero_cmd_done", cmd_done, 1);
            chk("zero_no_read", memoryRead_out, 0);
            chk("zero_ready", cmd_ready, 1);
            tick();
            chk("zero_done_drop", cmd_done, 0);
            chk("zero_no_read2", memoryRead_out, 0);
            return;
        end
        for (int i = 0; i < v.n; i++) begin
            wait_mr(w);
            chk("memoryRead_seen", memoryRead_out, 1);
            chk("issue_latency", w, 2);
            chk("address_out", address_out, v.ea[i]);
            chk("len_out", len_out, v.el[i]);
            chk("size_out", size_out, v.size);
            chk("burst_out", burst_out, v.burst);
            chk("prot_out", prot_out, v.prot);
            chk("busy_wait", busy, 1);
            chk("cmd_done_early", cmd_done, 0);
            stable = 1'b1;
            a0     = address_out;
            for (int d = 0; d < v.dly; d++) begin
                tick();
                if (!memoryRead_out || address_out !== a0 || len_out !== v.el[i]
                    || prot_out !== v.prot || burst_out !== v.burst)
                    stable = 1'b0;
            end
            if (v.dly > 0) chk("hold_stable", stable, 1);
            burst_ack = 1'b1;
            tick();
            burst_ack = 1'b0;
            exp_cnt++;
            chk("read_low_after_ack", memoryRead_out, 0);
            chk("cmd_done_at_ack", cmd_done, (i == v.n - 1) ? 1 : 0);
            chk("bursts_issued", bursts_issued, exp_cnt & 8'hFF);
        end
        tick();
        chk("cmd_done_one_cycle", cmd_done, 0);
        chk("ready_after_cmd", cmd_ready, 1);
        chk("busy_after_cmd", busy, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int w;
        logic seen_done;

        vecs[0] = '{addr:32'h1000, beats:16'd40, size:2'd2, burst:2'b01, prot:3'b010, n:3, dly:0,
                    ea:{32'h0, 32'h1080, 32'h1040, 32'h1000}, el:{4'h0, 4'h7, 4'hF, 4'hF}};
        vecs[1] = '{addr:32'h0FF0, beats:16'd10, size:2'd2, burst:2'b01, prot:3'b001, n:2, dly:1,
                    ea:{32'h0, 32'h0, 32'h1000, 32'h0FF0}, el:{4'h0, 4'h0, 4'h5, 4'h3}};
        vecs[2] = '{addr:32'h2004, beats:16'd20, size:2'd2, burst:2'b00, prot:3'b100, n:2, dly:0,
                    ea:{32'h0, 32'h0, 32'h2004, 32'h2004}, el:{4'h0, 4'h0, 4'h3, 4'hF}};
        vecs[3] = '{addr:32'h0, beats:16'd0, size:2'd2, burst:2'b01, prot:3'b000, n:0, dly:0,
                    ea:'0, el:'0};
        vecs[4] = '{addr:32'h1003, beats:16'd1, size:2'd2, burst:2'b01, prot:3'b111, n:1, dly:5,
                    ea:{32'h0, 32'h0, 32'h0, 32'h1000}, el:{4'h0, 4'h0, 4'h0, 4'h0}};
        vecs[5] = '{addr:32'h0FFE, beats:16'd4, size:2'd0, burst:2'b01, prot:3'b011, n:2, dly:2,
                    ea:{32'h0, 32'h0, 32'h1000, 32'h0FFE}, el:{4'h0, 4'h0, 4'h1, 4'h1}};
        vecs[6] = '{addr:32'h3FF8, beats:16'd3, size:2'd3, burst:2'b11, prot:3'b101, n:2, dly:0,
                    ea:{32'h0, 32'h0, 32'h4000, 32'h3FF8}, el:{4'h0, 4'h0, 4'h1, 4'h0}};

        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_read", memoryRead_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", bursts_issued, 0);
        chk("rst_addr", address_out, 0);
        ARESETn = 1'b1;
        tick();

        // Reset during WAIT_ACK of the second burst abandons the command.
        cmd_valid = 1'b1; cmd_addr = 32'h1000; cmd_beats = 16'd40; cmd_size = 2'd2;
        cmd_burst = 2'b01; cmd_prot = 3'b110;
        tick();
        cmd_valid = 1'b0;
        wait_mr(w);
        burst_ack = 1'b1; tick(); burst_ack = 1'b0;
        chk("pre_rst_count", bursts_issued, 1);
        wait_mr(w);
        chk("pre_rst_read", memoryRead_out, 1);
        ARESETn = 1'b0;
        #2;
        chk("mid_rst_read", memoryRead_out, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", bursts_issued, 0);
        chk("mid_rst_addr", address_out, 0);
        chk("mid_rst_fields", {len_out, size_out, burst_out, prot_out}, 0);
        chk("mid_rst_done", cmd_done, 0);
        tick();
        ARESETn = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cmd_done || memoryRead_out) seen_done = 1'b1;
        end
        chk("post_rst_quiet", seen_done, 0);
        exp_cnt = 0;

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        // Stray ack in IDLE must not move the counter.
        burst_ack = 1'b1; tick(); burst_ack = 1'b0; tick();
        chk("stray_ack_count", bursts_issued, exp_cnt & 8'hFF);
        chk("stray_ack_read", memoryRead_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
